// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with hardware return-address stack
//
// Selects the next PC every enabled cycle from increment, PC-relative branch,
// absolute jump, subroutine call or return, and keeps a return-address stack.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         advance enable (0 = stall, all state held)
//   set_pc     synchronous restart to RESET_VEC, empties stack, clears fault
//   br_take    take relative branch, base is the current pc
//   br_off     signed branch offset, sign-extended to PC_W
//   jmp        absolute jump to jmp_addr
//   call       push pc+1 and jump to jmp_addr
//   ret        pop top of stack into pc
//   jmp_addr   target for jmp and call
//   pc         current program counter (registered)
//   stk_empty  stack holds no entries
//   stk_full   stack holds STACK_DEPTH entries
//   fault      sticky over/underflow flag
module pc_seq #(
   parameter int              PC_W        = 4,
   parameter int              OFF_W       = 4,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             set_pc,
   input  logic             br_take,
   input  logic [OFF_W-1:0] br_off,
   input  logic             jmp,
   input  logic             call,
   input  logic             ret,
   input  logic [PC_W-1:0]  jmp_addr,
   output logic [PC_W-1:0]  pc,
   output logic             stk_empty,
   output logic             stk_full,
   output logic             fault
);

   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
   localparam logic [PC_W-1:0]  ONE_PC  = PC_W'(1);

   logic [PC_W-1:0]  stack [STACK_DEPTH];
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [PC_W-1:0]  off_ext;
   logic [PC_W-1:0]  pc_inc;
   logic             do_push;

   // Size cast of a signed operand sign-extends (or truncates) to PC_W.
   assign off_ext = PC_W'($signed(br_off));
   assign pc_inc  = pc + ONE_PC;

   // count doubles as the stack pointer: next free slot is count, top is count-1.
   assign wr_idx  = IDX_W'(count);
   assign rd_idx  = IDX_W'(count - ONE_CNT);

   assign stk_empty = (count == '0);
   assign stk_full  = (count == DEPTH_C);

   // Push only when a call is the winning action; ret outranks call.
   assign do_push = rst_n && !set_pc && en && !ret && call && !stk_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_VEC;
         count <= '0;
         fault <= 1'b0;
      end else if (set_pc) begin
         pc    <= RESET_VEC;
         count <= '0;
         fault <= 1'b0;
      end else if (en) begin
         if (ret) begin
            if (stk_empty) begin
               fault <= 1'b1;
            end else begin
               pc    <= stack[rd_idx];
               count <= count - ONE_CNT;
            end
         end else if (call) begin
            if (stk_full) begin
               fault <= 1'b1;
            end else begin
               pc    <= jmp_addr;
               count <= count + ONE_CNT;
            end
         end else if (jmp) begin
            pc <= jmp_addr;
         end else if (br_take) begin
            pc <= pc + off_ext;
         end else begin
            pc <= pc_inc;
         end
      end
   end

   // Entries at or above count are never read, so the array needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack[wr_idx] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq
module tb_pc_seq;

   localparam int PC_W  = 4;
   localparam int DEPTH = 4;
   localparam int MODV  = 1 << PC_W;

   logic       clk = 1'b0;
   logic       rst_n, en, set_pc, br_take, jmp, call, ret;
   logic [3:0] br_off, jmp_addr;
   logic [3:0] pc;
   logic       stk_empty, stk_full, fault;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural reference: plain integers and a queue as the stack.
   int m_pc;
   int m_stk[$];
   bit m_fault;

   typedef struct {
      logic       s, e, b;
      logic [3:0] off;
      logic       j, c, r;
      logic [3:0] a;
      logic [3:0] epc;
      logic       ee, ef, efa;
   } vec_t;

   vec_t tbl[18];

   pc_seq #(.PC_W(4), .OFF_W(4), .STACK_DEPTH(DEPTH), .RESET_VEC(4'h0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .set_pc(set_pc), .br_take(br_take),
      .br_off(br_off), .jmp(jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr),
      .pc(pc), .stk_empty(stk_empty), .stk_full(stk_full), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic s, logic e, logic b, logic [3:0] off, logic j, logic c,
                               logic r, logic [3:0] a, logic [3:0] epc, logic ee, logic ef,
                               logic efa);
      vec_t v;
      v.s = s; v.e = e; v.b = b; v.off = off; v.j = j; v.c = c; v.r = r; v.a = a;
      v.epc = epc; v.ee = ee; v.ef = ef; v.efa = efa;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_stk.delete();
      m_fault = 0;
   endtask

   task automatic model_step();
      int off;
      if (set_pc) begin
         model_reset();
      end else if (en) begin
         if (ret) begin
            if (m_stk.size() == 0) m_fault = 1;
            else m_pc = m_stk.pop_back();
         end else if (call) begin
            if (m_stk.size() == DEPTH) m_fault = 1;
            else begin
               m_stk.push_back((m_pc + 1) % MODV);
               m_pc = int'(jmp_addr);
            end
         end else if (jmp) begin
            m_pc = int'(jmp_addr);
         end else if (br_take) begin
            off = (br_off >= 8) ? int'(br_off) - 16 : int'(br_off);
            m_pc = (m_pc + off + MODV) % MODV;
         end else begin
            m_pc = (m_pc + 1) % MODV;
         end
      end
   endtask

   task automatic drive(input logic s, input logic e, input logic b, input logic [3:0] off,
                        input logic j, input logic c, input logic r, input logic [3:0] a);
      set_pc = s; en = e; br_take = b; br_off = off; jmp = j; call = c; ret = r; jmp_addr = a;
   endtask

   // Apply current inputs for one edge, advance the model, sample #1 after the edge.
   task automatic step_model(input string name);
      model_step();
      @(posedge clk);
      #1;
      check({name, ".pc"}, int'(pc), m_pc);
      check({name, ".empty"}, int'(stk_empty), int'(m_stk.size() == 0));
      check({name, ".full"}, int'(stk_full), int'(m_stk.size() == DEPTH));
      check({name, ".fault"}, int'(fault), int'(m_fault));
   endtask

   task automatic expect_state(input string name, input int epc, input int ee, input int ef,
                               input int efa);
      check({name, ".pc"}, int'(pc), epc);
      check({name, ".empty"}, int'(stk_empty), ee);
      check({name, ".full"}, int'(stk_full), ef);
      check({name, ".fault"}, int'(fault), efa);
   endtask

   task automatic step_exp(input string name, input int epc, input int ee, input int ef,
                           input int efa);
      model_step();
      @(posedge clk);
      #1;
      expect_state(name, epc, ee, ef, efa);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      expect_state("reset", 0, 1, 0, 0);

      // Reset release and 17 increments with wrap.
      rst_n = 1'b1;
      drive(0, 1, 0, 4'h0, 0, 0, 0, 4'h0);
      for (int k = 1; k <= 17; k++) step_exp($sformatf("inc%0d", k), k % 16, 1, 0, 0);

      // Table of branch, nesting, priority and stall cases, starting from set_pc.
      tbl[0]  = mk(1, 1, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
      tbl[1]  = mk(0, 1, 0, 4'h0, 1, 0, 0, 4'h3, 4'h3, 1, 0, 0);
      tbl[2]  = mk(0, 1, 1, 4'hE, 0, 0, 0, 4'h0, 4'h1, 1, 0, 0);
      tbl[3]  = mk(0, 1, 1, 4'hE, 0, 0, 0, 4'h0, 4'hF, 1, 0, 0);
      tbl[4]  = mk(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
      tbl[5]  = mk(0, 1, 0, 4'h0, 1, 0, 0, 4'h2, 4'h2, 1, 0, 0);
      tbl[6]  = mk(0, 1, 0, 4'h0, 0, 1, 0, 4'h8, 4'h8, 0, 0, 0);
      tbl[7]  = mk(0, 1, 0, 4'h0, 0, 1, 0, 4'hC, 4'hC, 0, 0, 0);
      tbl[8]  = mk(0, 1, 0, 4'h0, 0, 0, 1, 4'h0, 4'h9, 0, 0, 0);
      tbl[9]  = mk(0, 1, 0, 4'h0, 0, 0, 1, 4'h0, 4'h3, 1, 0, 0);
      tbl[10] = mk(0, 1, 1, 4'h7, 1, 1, 0, 4'h5, 4'h5, 0, 0, 0);
      tbl[11] = mk(0, 1, 0, 4'h0, 0, 1, 1, 4'h7, 4'h4, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 4'h0, 1, 0, 0, 4'hA, 4'h4, 1, 0, 0);
      tbl[13] = mk(0, 0, 0, 4'h0, 1, 0, 0, 4'hA, 4'h4, 1, 0, 0);
      tbl[14] = mk(0, 0, 0, 4'h0, 1, 0, 0, 4'hA, 4'h4, 1, 0, 0);
      tbl[15] = mk(1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
      tbl[16] = mk(0, 1, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0, 1, 0, 1);
      tbl[17] = mk(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 4'h1, 1, 0, 1);
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].s, tbl[i].e, tbl[i].b, tbl[i].off, tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].a);
         step_exp($sformatf("tbl%0d", i), int'(tbl[i].epc), int'(tbl[i].ee), int'(tbl[i].ef),
                  int'(tbl[i].efa));
      end

      // Overflow: four calls fill, fifth holds pc and faults; set_pc clears; ret empty faults.
      drive(1, 1, 0, 4'h0, 0, 0, 0, 4'h0);
      step_exp("ov.set", 0, 1, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'hA); step_exp("ov.c1", 'hA, 0, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'hB); step_exp("ov.c2", 'hB, 0, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'hC); step_exp("ov.c3", 'hC, 0, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'hD); step_exp("ov.c4", 'hD, 0, 1, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'h5); step_exp("ov.c5", 'hD, 0, 1, 1);
      drive(0, 1, 0, 4'h0, 0, 0, 1, 4'h0); step_exp("ov.r1", 'hD, 0, 0, 1);
      drive(1, 0, 0, 4'h0, 0, 0, 0, 4'h0); step_exp("ov.clr", 0, 1, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 0, 1, 4'h0); step_exp("un.ret", 0, 1, 0, 1);

      // Async reset between edges while a call is pending.
      drive(1, 1, 0, 4'h0, 0, 0, 0, 4'h0); step_exp("ar.set", 0, 1, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'h9); step_exp("ar.c1", 9, 0, 0, 0);
      drive(0, 1, 0, 4'h0, 0, 1, 0, 4'h6);
      #2;
      rst_n = 1'b0;
      #1;
      expect_state("ar.now", 0, 1, 0, 0);
      @(posedge clk);
      #1;
      expect_state("ar.hold", 0, 1, 0, 0);
      model_reset();
      rst_n = 1'b1;
      drive(0, 1, 0, 4'h0, 0, 0, 1, 4'h0);
      step_exp("ar.ret", 0, 1, 0, 1);

      // Randomised run against the queue model.
      drive(1, 1, 0, 4'h0, 0, 0, 0, 4'h0);
      step_model("rnd.set");
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85),
               ($urandom_range(0, 99) < 30), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 99) < 25), 4'($urandom_range(0, 15)));
         step_model($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
